decode_issue_ctrl: RTL and testbench

- Sequences the decoder: accepts one RV32I instruction word from fetch, checks register hazards against a 32-entry scoreboard, pulses the decoder enable, waits out decoder latency, then presents the decoded result to execute with a valid/ready handshake.
- Writeback clears scoreboard entries.
- Sits between fetch, the decoder and execute in the core.

---
 rtl/decode_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Decode/issue sequencer: accepts an RV32I word from fetch, holds it in CHECK
// until the register scoreboard shows no hazard, pulses the decoder enable,
// waits out the decoder latency, then offers the result to execute.
module decode_issue_ctrl #(
  parameter int unsigned DECODE_LAT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  output logic             if_ready,
  output logic             dec_enable,
  output logic [31:0]      dec_instr,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic             ex_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [31:0]      busy_mask,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned LatW = $clog2(DECODE_LAT + 1);

  typedef enum logic [1:0] {StIdle, StCheck, StWait, StIssue} state_e;

  state_e           r_state;
  logic [31:0]      r_instr;
  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [LatW-1:0]  r_lat_cnt;
  logic             r_illegal;
  logic             r_set_vld;
  logic [4:0]       r_set_rd;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_writes_rd;
  logic        w_illegal;
  logic [31:0] w_wb_clr;
  logic [31:0] w_busy_eff;
  logic [31:0] w_set;
  logic [31:0] w_flush_clr;
  logic [31:0] w_busy_nxt;
  logic        w_hazard;
  logic        w_in_check;
  logic        w_dec_fire;
  logic        w_stall;
  logic        w_flush_act;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];

  // Register usage by opcode; anything unrecognised is an illegal NOP.
  always_comb begin
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_writes_rd = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_use_rs1   = 1'b1;
        w_writes_rd = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        w_writes_rd = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Hazard is judged against the scoreboard after this cycle's writeback clear.
  always_comb begin
    w_wb_clr    = (wb_valid && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
    w_busy_eff  = r_busy & ~w_wb_clr;
    w_hazard    = (w_use_rs1 && (w_rs1 != 5'd0) && w_busy_eff[w_rs1]) ||
                  (w_use_rs2 && (w_rs2 != 5'd0) && w_busy_eff[w_rs2]) ||
                  (w_writes_rd && (w_rd != 5'd0) && w_busy_eff[w_rd]);
    w_flush_act = flush && (r_state != StIdle);
    w_in_check  = (r_state == StCheck) && !flush;
    w_dec_fire  = w_in_check && !w_hazard;
    w_stall     = w_in_check && w_hazard;
    w_set       = (w_dec_fire && w_writes_rd && (w_rd != 5'd0)) ? (32'd1 << w_rd) : 32'd0;
    w_flush_clr = (flush && r_set_vld && ((r_state == StWait) || (r_state == StIssue))) ?
                  (32'd1 << r_set_rd) : 32'd0;
    // Set is OR-ed last so it wins over a same-cycle writeback clear.
    w_busy_nxt  = ((r_busy & ~w_wb_clr & ~w_flush_clr) | w_set) & ~32'd1;
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    if_ready   = rst && (r_state == StIdle);
    dec_enable = rst && w_dec_fire;
    dec_instr  = rst ? r_instr : 32'd0;
    ex_valid   = rst && (r_state == StIssue);
    ex_illegal = rst && (r_state == StIssue) && r_illegal;
    stall      = rst && w_stall;
    busy_mask  = rst ? r_busy : 32'd0;
    sb_err     = rst && wb_valid && (wb_rd != 5'd0) && !r_busy[wb_rd];
    stall_cnt  = rst ? r_stall_cnt : '0;
  end

  // Sequencer state, scoreboard and stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_instr     <= 32'd0;
      r_busy      <= 32'd0;
      r_stall_cnt <= '0;
      r_lat_cnt   <= '0;
      r_illegal   <= 1'b0;
      r_set_vld   <= 1'b0;
      r_set_rd    <= 5'd0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_act) begin
        r_state   <= StIdle;
        r_set_vld <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (if_valid) begin
              r_instr <= if_instr;
              r_state <= StCheck;
            end
          end
          StCheck: begin
            if (!w_hazard) begin
              r_state   <= StWait;
              r_lat_cnt <= LatW'(DECODE_LAT);
              r_illegal <= w_illegal;
              r_set_vld <= w_writes_rd && (w_rd != 5'd0);
              r_set_rd  <= w_rd;
            end
          end
          StWait: begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
            if (r_lat_cnt == LatW'(1)) begin
              r_state <= StIssue;
            end
          end
          StIssue: begin
            if (ex_ready) begin
              r_state   <= StIdle;
              r_set_vld <= 1'b0;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-style reference model.
module tb_decode_issue_ctrl;

  localparam int unsigned DL = 2;
  localparam int unsigned CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic          if_ready;
  logic          dec_enable;
  logic [31:0]   dec_instr;
  logic          ex_valid;
  logic          ex_ready;
  logic          ex_illegal;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          flush;
  logic          stall;
  logic [31:0]   busy_mask;
  logic          sb_err;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_issue_ctrl #(
    .DECODE_LAT (DL),
    .CNT_W      (CW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_ready   (if_ready),
    .dec_enable (dec_enable),
    .dec_instr  (dec_instr),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_illegal (ex_illegal),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .stall      (stall),
    .busy_mask  (busy_mask),
    .sb_err     (sb_err),
    .stall_cnt  (stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an instruction is held, then decoded, then counts down to issue.
  bit          m_have;
  bit          m_decoded;
  int          m_wait_left;
  logic [31:0] m_instr;
  bit          m_busy [32];
  int          m_cnt;
  bit          m_illegal;
  int          m_set_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have      = 1'b0;
    m_decoded   = 1'b0;
    m_wait_left = 0;
    m_instr     = 32'd0;
    m_cnt       = 0;
    m_illegal   = 1'b0;
    m_set_rd    = -1;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  function automatic void classify(input logic [31:0] ins, output bit r1, output bit r2,
                                   output bit wr, output bit ill);
    r1 = 0; r2 = 0; wr = 0; ill = 0;
    case (ins[6:0])
      7'h33:               begin r1 = 1; r2 = 1; wr = 1; end
      7'h13, 7'h03, 7'h67: begin r1 = 1; wr = 1; end
      7'h23, 7'h63:        begin r1 = 1; r2 = 1; end
      7'h37, 7'h17, 7'h6F: wr = 1;
      default:             ill = 1;
    endcase
  endfunction

  // One clock: drive inputs, compare outputs, then advance the model past the edge.
  task automatic step(input bit i_rst, input bit i_ifv, input logic [31:0] i_ins,
                      input bit i_wbv, input int i_wbrd, input bit i_exr, input bit i_fl);
    bit idle, check, waiting, issue, r1, r2, wr, ill, hazard;
    bit e_dec, e_stall;
    int rd, rs1, rs2;
    logic [31:0] e_busy;
    @(negedge clk);
    rst      = i_rst;
    if_valid = i_ifv;
    if_instr = i_ins;
    wb_valid = i_wbv;
    wb_rd    = 5'(i_wbrd);
    ex_ready = i_exr;
    flush    = i_fl;
    #1;
    idle    = !m_have;
    check   = m_have && !m_decoded;
    waiting = m_decoded && (m_wait_left > 0);
    issue   = m_decoded && (m_wait_left == 0);
    classify(m_instr, r1, r2, wr, ill);
    rd  = int'(m_instr[11:7]);
    rs1 = int'(m_instr[19:15]);
    rs2 = int'(m_instr[24:20]);
    hazard = 0;
    if (r1 && rs1 != 0 && m_busy[rs1] && !(i_wbv && i_wbrd == rs1)) hazard = 1;
    if (r2 && rs2 != 0 && m_busy[rs2] && !(i_wbv && i_wbrd == rs2)) hazard = 1;
    if (wr && rd != 0 && m_busy[rd] && !(i_wbv && i_wbrd == rd)) hazard = 1;
    e_dec   = i_rst && check && !i_fl && !hazard;
    e_stall = i_rst && check && !i_fl && hazard;
    e_busy  = 32'd0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) e_busy[i] = 1'b1;
    if (!i_rst) e_busy = 32'd0;

    check_val("if_ready",   32'(if_ready),   32'(i_rst && idle));
    check_val("dec_enable", 32'(dec_enable), 32'(e_dec));
    check_val("dec_instr",  dec_instr,       i_rst ? m_instr : 32'd0);
    check_val("ex_valid",   32'(ex_valid),   32'(i_rst && issue));
    check_val("ex_illegal", 32'(ex_illegal), 32'(i_rst && issue && m_illegal));
    check_val("stall",      32'(stall),      32'(e_stall));
    check_val("busy_mask",  busy_mask,       e_busy);
    check_val("sb_err",     32'(sb_err),     32'(i_rst && i_wbv && i_wbrd != 0 && !m_busy[i_wbrd]));
    check_val("stall_cnt",  32'(stall_cnt),  i_rst ? 32'(m_cnt) : 32'd0);

    if (!i_rst) begin
      model_reset();
    end else begin
      if (i_wbv && i_wbrd != 0) m_busy[i_wbrd] = 1'b0;
      if (i_fl && (waiting || issue) && m_set_rd > 0) m_busy[m_set_rd] = 1'b0;
      if (e_stall && m_cnt < CntMax) m_cnt++;
      if (i_fl && !idle) begin
        m_have    = 1'b0;
        m_decoded = 1'b0;
        m_set_rd  = -1;
      end else if (idle) begin
        if (i_ifv) begin
          m_have    = 1'b1;
          m_decoded = 1'b0;
          m_instr   = i_ins;
        end
      end else if (e_dec) begin
        m_decoded   = 1'b1;
        m_wait_left = DL;
        m_illegal   = ill;
        m_set_rd    = -1;
        if (wr && rd != 0) begin
          m_busy[rd] = 1'b1;
          m_set_rd   = rd;
        end
      end else if (waiting) begin
        m_wait_left--;
      end else if (issue && i_exr) begin
        m_have    = 1'b0;
        m_decoded = 1'b0;
        m_set_rd  = -1;
      end
    end
  endtask

  task automatic idle_n(input int n, input bit exr);
    for (int i = 0; i < n; i++) step(1, 0, 32'd0, 0, 0, exr, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00, 7'h0B};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    rst = 0; if_valid = 0; if_instr = 0; wb_valid = 0; wb_rd = 0; ex_ready = 0; flush = 0;
    model_reset();

    // Reset, then ADD x5,x1,x2 flowing straight through.
    step(0, 0, 32'd0, 0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFF, 1, 3, 1, 0);
    step(1, 1, 32'h0020_82B3, 0, 0, 1, 0);
    idle_n(5, 1);
    // RAW: ADDI x6,x5,1 stalls until x5 writes back in the same cycle.
    step(1, 1, 32'h0012_8313, 0, 0, 1, 0);
    idle_n(3, 1);
    step(1, 0, 32'd0, 1, 5, 1, 0);
    idle_n(4, 1);
    // x0: ADD x0,x0,x0 sets nothing; writeback to x0 is silent.
    step(1, 1, 32'h0000_0033, 0, 0, 1, 0);
    idle_n(5, 1);
    step(1, 0, 32'd0, 1, 0, 1, 0);
    // Collision: x7 busy, second write to x7 passes CHECK as x7 writes back.
    step(1, 1, 32'h0010_0393, 0, 0, 1, 0);
    idle_n(5, 1);
    step(1, 1, 32'h0020_0393, 0, 0, 1, 0);
    idle_n(2, 1);
    step(1, 0, 32'd0, 1, 7, 1, 0);
    idle_n(4, 1);
    // Writeback to a clear register.
    step(1, 0, 32'd0, 1, 9, 1, 0);
    // Backpressure then flush in ISSUE with ex_ready high.
    step(1, 1, 32'h0020_8433, 0, 0, 0, 0);
    idle_n(9, 0);
    step(1, 0, 32'd0, 0, 0, 1, 1);
    idle_n(2, 1);
    // Illegal opcode.
    step(1, 1, 32'h0000_007F, 0, 0, 0, 0);
    idle_n(5, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);
    // Reset during WAIT.
    step(1, 1, 32'h0020_82B3, 0, 0, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);
    step(0, 0, 32'd0, 0, 0, 1, 0);
    idle_n(3, 1);
    // Long stall to saturate the counter.
    step(1, 1, 32'h0010_0193, 0, 0, 1, 0);
    idle_n(5, 1);
    step(1, 1, 32'h0031_8233, 0, 0, 1, 0);
    idle_n(22, 1);
    step(1, 0, 32'd0, 1, 3, 1, 0);
    idle_n(5, 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bit r, fl;
      r  = ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 99) < 5) && !(m_have && !m_decoded);
      step(r, ($urandom_range(0, 1) == 1), rand_instr(), ($urandom_range(0, 9) < 3),
           int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6), fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
